// File: rtl/ssds_scanner.sv
// ssds_scanner: time-multiplexed seven-segment display scanner.
//
// Keeps a tear-free shadow of a hex value, per-digit dots and enables. New
// contents arrive through a one-entry pending buffer (valid/ready) and are
// copied into the shadow only at a frame boundary. Digits are selected
// round-robin for SLOT_CYCLES clocks each. Within a slot, a PWM gate taken
// from the low slot-counter bits sets the brightness. All pin outputs are
// registered.
//
// Optional feature: define SSDS_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 always shown, a set dot stops the blanking).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   upd_value         4*DIGITS nibbles, digit 0 least significant
//   upd_dots          per-digit decimal point
//   upd_enables       per-digit enable (0 blanks the digit)
//   upd_valid         update offer
//   upd_ready         pending buffer empty, an update can be taken
//   brightness        live PWM duty (all-ones = fully on, 0 = off)
//   segments, dp      {g,f,e,d,c,b,a} and decimal point, SEG_ACTIVE_LOW polarity
//   digit_sel         one-hot digit select, SEL_ACTIVE_LOW polarity
//   frame_done        one-cycle pulse after each full scan
module ssds_scanner #(
  parameter int DIGITS         = 4,
  parameter int SLOT_CYCLES    = 50000,
  parameter int BRIGHT_W       = 3,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   upd_value,
  input  logic [DIGITS-1:0]     upd_dots,
  input  logic [DIGITS-1:0]     upd_enables,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  // Standard hex font, active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      4'hF: f = 7'h71;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  logic [CNT_W-1:0]    slot_cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic                slot_tc_s;
  logic                frame_end_s;

  logic [4*DIGITS-1:0] pend_val_r;
  logic [DIGITS-1:0]   pend_dots_r;
  logic [DIGITS-1:0]   pend_en_r;
  logic [4*DIGITS-1:0] shadow_val_r;
  logic [DIGITS-1:0]   shadow_dots_r;
  logic [DIGITS-1:0]   shadow_en_r;
  logic                upd_ready_r;
  logic                frame_done_r;

  logic [3:0]          cur_nib_s;
  logic                cur_dot_s;
  logic                cur_en_s;
  logic [DIGITS-1:0]   sel_onehot_s;
  logic                lead_zero_s;
  logic                lz_blank_s;
  logic                pwm_open_s;
  logic                lit_s;

  logic [6:0]          segments_r;
  logic                dp_r;
  logic [DIGITS-1:0]   digit_sel_r;

  assign slot_tc_s   = (slot_cnt_r == SLOT_LAST);
  assign frame_end_s = slot_tc_s && (idx_r == IDX_LAST);

  // Slot counter and round-robin digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
      idx_r      <= '0;
    end else if (slot_tc_s) begin
      slot_cnt_r <= '0;
      idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_W'(1);
    end
  end

  // Pending buffer and shadow. upd_ready_r doubles as "pending empty", so a
  // transfer and a boundary copy can never happen in the same cycle; a
  // transfer landing on a boundary waits for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_ready_r   <= 1'b1;
      pend_val_r    <= '0;
      pend_dots_r   <= '0;
      pend_en_r     <= '0;
      shadow_val_r  <= '0;
      shadow_dots_r <= '0;
      shadow_en_r   <= '0;
    end else if (frame_end_s && !upd_ready_r) begin
      shadow_val_r  <= pend_val_r;
      shadow_dots_r <= pend_dots_r;
      shadow_en_r   <= pend_en_r;
      upd_ready_r   <= 1'b1;
    end else if (upd_valid && upd_ready_r) begin
      pend_val_r    <= upd_value;
      pend_dots_r   <= upd_dots;
      pend_en_r     <= upd_enables;
      upd_ready_r   <= 1'b0;
    end
  end

  // Frame pulse, registered one cycle after the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
    end
  end

  // Select the current digit's shadow data; walks from the most significant
  // digit down so lead_zero_s tracks "this and all higher digits are blank".
  always_comb begin
    cur_nib_s    = 4'h0;
    cur_dot_s    = 1'b0;
    cur_en_s     = 1'b0;
    sel_onehot_s = '0;
    lead_zero_s  = 1'b1;
    lz_blank_s   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero_s     = lead_zero_s && (shadow_val_r[4*i +: 4] == 4'h0) && !shadow_dots_r[i];
      sel_onehot_s[i] = (idx_r == IDX_W'(i));
      cur_nib_s       = sel_onehot_s[i] ? shadow_val_r[4*i +: 4] : cur_nib_s;
      cur_dot_s       = sel_onehot_s[i] ? shadow_dots_r[i] : cur_dot_s;
      cur_en_s        = sel_onehot_s[i] ? shadow_en_r[i] : cur_en_s;
`ifdef SSDS_LEADING_ZERO_BLANK_EN
      lz_blank_s      = (sel_onehot_s[i] && (i > 0)) ? lead_zero_s : lz_blank_s;
`else
      lz_blank_s      = 1'b0;
`endif
    end
    pwm_open_s = (brightness == {BRIGHT_W{1'b1}}) ||
                 (slot_cnt_r[BRIGHT_W-1:0] < brightness);
    lit_s      = cur_en_s && pwm_open_s && !lz_blank_s;
  end

  // Registered pin stage; an unlit digit drives everything inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments_r  <= {7{SEG_INV}};
      dp_r        <= SEG_INV;
      digit_sel_r <= {DIGITS{SEL_INV}};
    end else if (lit_s) begin
      segments_r  <= hex_font(cur_nib_s) ^ {7{SEG_INV}};
      dp_r        <= cur_dot_s ^ SEG_INV;
      digit_sel_r <= sel_onehot_s ^ {DIGITS{SEL_INV}};
    end else begin
      segments_r  <= {7{SEG_INV}};
      dp_r        <= SEG_INV;
      digit_sel_r <= {DIGITS{SEL_INV}};
    end
  end

  assign upd_ready  = upd_ready_r;
  assign frame_done = frame_done_r;
  assign segments   = segments_r;
  assign dp         = dp_r;
  assign digit_sel  = digit_sel_r;

endmodule

// File: doc/ssds_scanner.md
Name: ssds_scanner

Overview:
- Time-multiplexed driver for a bank of common-anode/cathode seven-segment digits sharing one segment bus.
- Holds a tear-free shadow copy of a hex value plus per-digit decimal points and enables.
- Scans digits round-robin at a fixed slot length, decodes each nibble with the team's standard hex font, and applies PWM brightness within each slot.
- Sits between the memory-mapped SSD peripheral registers and the board pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- SLOT_CYCLES, 50000, clock cycles each digit is selected; must be a multiple of 2**BRIGHT_W and >= 2**BRIGHT_W.
- BRIGHT_W, 3, brightness control width.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp pins active-low; 0 = active-high.
- SEL_ACTIVE_LOW, 1, 1 = digit select pins active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- upd_value  in  4*DIGITS  nibble i is digit i; digit 0 is least significant.
- upd_dots  in  DIGITS  decimal point per digit.
- upd_enables  in  DIGITS  per-digit enable; 0 blanks the digit.
- upd_valid  in  1  update offer.
- upd_ready  out  1  update can be accepted.
- brightness  in  BRIGHT_W  live PWM duty, not shadowed.
- segments  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
- digit_sel  out  DIGITS  one-hot select, polarity per SEL_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (async assert, sync release):
  - slot counter = 0, digit index = 0.
  - Shadow value, dots and enables = 0; pending buffer empty.
  - upd_ready = 1, frame_done = 0.
  - All segments, dp and digit_sel driven inactive.
- Slot counter: counts 0..SLOT_CYCLES-1. At terminal count it wraps to 0 and the index advances (DIGITS-1 wraps to 0).
- Frame boundary = the cycle the index wraps DIGITS-1 -> 0.
  - frame_done is registered high for exactly the following cycle.
- Update handshake:
  - Transfer occurs when upd_valid && upd_ready; value, dots and enables are captured into the pending buffer.
  - upd_ready drops the next cycle and stays low while the pending buffer is full.
  - Pending contents copy into the shadow at the next frame boundary; upd_ready returns high the cycle after.
  - A transfer coinciding with a frame boundary is applied at the following boundary, never mid-frame.
  - upd_valid with upd_ready low is ignored; no stall or overwrite.
- Output stage is registered; outputs reflect the index and counter one cycle later.
- Digit i is lit when all of the following hold: index == i, shadow enable i = 1, and the PWM gate is open.
- PWM gate: open when slot_count[BRIGHT_W-1:0] < brightness, or when brightness is all-ones (fully on).
  - brightness = 0 means digit_sel is always inactive.
- When a digit is not lit: digit_sel, segments and dp are all inactive (ghost-free blanking).
- Hex font, active-high {g..a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Changes to brightness take effect on the next cycle.
- Reset mid-scan returns to index 0 and discards any pending update.

Optional Feature:
- Macro SSDS_LEADING_ZERO_BLANK_EN.
- Defined: a digit i > 0 is additionally blanked when its shadow nibble and every more-significant nibble are 0 and none of those digits has its dot set. Digit 0 is never blanked by this rule.
- Undefined: zeros are always displayed.
- Blanking is evaluated against the shadow, not the pending buffer.

Test Plan (DIGITS=4, SLOT_CYCLES=8, BRIGHT_W=2, both polarities active-low):
- Reset, then release with brightness=3 -> all outputs inactive through reset; after release digit_sel cycles 1110, 1101, 1011, 0111, each held 8 cycles; frame_done pulses every 32 cycles.
- Update value=16'h1A3F, enables=4'hF, dots=0 -> no change before the next frame_done; after it, segments show ~7'h71, ~7'h4F, ~7'h77, ~7'h06 on digits 0..3.
- Second upd_valid while upd_ready=0 -> ignored; the shadow holds the first update.
- brightness=1 -> digit_sel active for 2 of every 8 cycles per slot. brightness=0 -> never active.
- enables=4'b1011 -> digit 2 slot: digit_sel all 1s, segments all 1s.
- With SSDS_LEADING_ZERO_BLANK_EN, value=16'h0050, dots=0 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0. With dots=4'b1000 -> digit 3 shows 0 with dp lit.
